gas_alarm_controller: RTL and testbench

//  Consumes the 3-bit event code from the gas detector FSM and sequences the home's response.

---
 rtl/gas_ctrl_pkg.sv | 35 +++
 rtl/gas_alarm_controller_if.sv | 34 +++
 rtl/gas_hold_timer.sv | 26 ++
 rtl/gas_alarm_controller.sv | 185 ++++++++++++++++++
 tb/tb_gas_alarm_controller.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/gas_ctrl_pkg.sv
// Shared definitions for the gas alarm controller: FSM state encoding,
// detector event bit positions, alarm level codes and the state-to-level map.
package gas_ctrl_pkg;

    // Bit positions inside det_code; a higher index means a more severe event
    localparam int CODE_LEAK = 2;
    localparam int CODE_HIGH = 1;
    localparam int CODE_LOW  = 0;

    // Values presented on alarm_level
    localparam logic [1:0] LVL_IDLE  = 2'd0;
    localparam logic [1:0] LVL_WARN  = 2'd1;
    localparam logic [1:0] LVL_ALARM = 2'd2;
    localparam logic [1:0] LVL_SHUT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARN,
        ST_ALARM,
        ST_SHUTDOWN,
        ST_VENT
    } state_t;

    // SHUTDOWN and VENT share the top level; the operator sees one "shut" state
    function automatic logic [1:0] level_of(state_t s);
        case (s)
            ST_WARN:     return LVL_WARN;
            ST_ALARM:    return LVL_ALARM;
            ST_SHUTDOWN: return LVL_SHUT;
            ST_VENT:     return LVL_SHUT;
            default:     return LVL_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/gas_alarm_controller_if.sv
// Detector/operator inputs and actuator outputs of the gas alarm controller.
// Build option GAS_CTRL_LOG_EN adds the shutdown_cnt / last_code log signals.
interface gas_alarm_controller_if;
    logic [2:0] det_code;
    logic       user_ack;
    logic       user_reset;
    logic [1:0] alarm_level;
    logic       fan_on;
    logic       buzzer;
    logic       valve_close;
    logic       irq;
`ifdef GAS_CTRL_LOG_EN
    logic [7:0] shutdown_cnt;
    logic [2:0] last_code;
`endif

    // Side that produces events and watches the actuators
    modport master (
        output det_code, user_ack, user_reset,
`ifdef GAS_CTRL_LOG_EN
        input  shutdown_cnt, last_code,
`endif
        input  alarm_level, fan_on, buzzer, valve_close, irq
    );

    // The controller itself
    modport slave (
        input  det_code, user_ack, user_reset,
`ifdef GAS_CTRL_LOG_EN
        output shutdown_cnt, last_code,
`endif
        output alarm_level, fan_on, buzzer, valve_close, irq
    );
endinterface

// File: rtl/gas_hold_timer.sv
// Loadable down-counter shared by the WARN/ALARM hold windows and the
// post-shutdown ventilation phase. Stops at zero; load wins over decrement.
module gas_hold_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_count;

    // Reload on request, otherwise count down and park at zero
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (arst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_val;
        else if (r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign o_zero = (r_count == '0);
endmodule

// File: rtl/gas_alarm_controller.sv
// Gas alarm controller: escalates IDLE -> WARN -> ALARM -> SHUTDOWN on
// detector events, holds levels with a shared timer, ventilates after a
// manual reset and raises irq on every escalation until acknowledged.
// Build option GAS_CTRL_LOG_EN adds a shutdown entry counter and last event code.
module gas_alarm_controller
    import gas_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int VENT_CYCLES   = 64,
    parameter int BEEP_HALF     = 4,
    parameter int WARN_ESCALATE = 3
) (
    input  logic             clk,
    input  logic             arst,
    gas_alarm_controller_if.slave bus
);
    localparam int TMR_W  = $clog2((HOLD_CYCLES > VENT_CYCLES) ? HOLD_CYCLES : VENT_CYCLES);
    localparam int WARN_W = $clog2(WARN_ESCALATE + 1);
    localparam int BEEP_W = $clog2(BEEP_HALF + 1);

    localparam logic [TMR_W-1:0]  HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0]  VENT_LOAD = TMR_W'(VENT_CYCLES - 1);
    localparam logic [WARN_W-1:0] WARN_SAT  = WARN_W'(WARN_ESCALATE);
    localparam logic [WARN_W-1:0] WARN_LAST = WARN_W'(WARN_ESCALATE - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);

    state_t            r_state;
    logic [WARN_W-1:0] r_warn_cnt;
    logic [BEEP_W-1:0] r_beep_cnt;
    logic [1:0]        r_level;
    logic              r_fan, r_buzzer, r_valve, r_irq;

    state_t            w_next;
    logic [WARN_W-1:0] w_warn_next;
    logic              w_load, w_rearm, w_escalate, w_tmr_zero;
    logic [TMR_W-1:0]  w_load_val;
    logic              w_leak, w_high, w_low, w_any;

    assign w_leak = bus.det_code[CODE_LEAK];
    assign w_high = bus.det_code[CODE_HIGH];
    assign w_low  = bus.det_code[CODE_LOW];
    assign w_any  = (bus.det_code != 3'b000);

    gas_hold_timer #(.WIDTH(TMR_W)) u_timer (
        .clk        (clk),
        .arst       (arst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_tmr_zero)
    );

    // Next state, warn counter and timer load; if/else order gives [2] > [1] > [0]
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_next      = r_state;
        w_warn_next = r_warn_cnt;
        w_load      = 1'b0;
        w_load_val  = HOLD_LOAD;
        w_rearm     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load = w_any;
                if (w_leak)      w_next = ST_SHUTDOWN;
                else if (w_high) w_next = ST_ALARM;
                else if (w_low) begin
                    w_next      = ST_WARN;
                    w_warn_next = WARN_W'(1);
                end
            end
            ST_WARN: begin
                if (w_leak) begin
                    w_next      = ST_SHUTDOWN;
                    w_warn_next = '0;
                end else if (w_high) begin
                    w_next = ST_ALARM;
                    w_load = 1'b1;
                end else if (w_low) begin
                    w_load = 1'b1;
                    if (r_warn_cnt >= WARN_LAST) begin
                        w_next      = ST_ALARM;
                        w_warn_next = WARN_SAT;
                    end else begin
                        w_warn_next = r_warn_cnt + 1'b1;
                    end
                end else if (w_tmr_zero) begin
                    w_next      = ST_IDLE;
                    w_warn_next = '0;
                end
            end
            ST_ALARM: begin
                if (w_leak) begin
                    w_next = ST_SHUTDOWN;
                end else if (w_high || w_low) begin
                    w_load = 1'b1;
                end else if (w_tmr_zero) begin
                    w_next      = ST_WARN;
                    w_load      = 1'b1;
                    w_warn_next = '0;
                end
            end
            ST_SHUTDOWN: begin
                // A fresh leak while already shut down is a new escalation for the operator
                w_rearm = w_leak;
                if (bus.user_reset && !w_any) begin
                    w_next     = ST_VENT;
                    w_load     = 1'b1;
                    w_load_val = VENT_LOAD;
                end
            end
            ST_VENT: begin
                if (w_any)           w_next = ST_SHUTDOWN;
                else if (w_tmr_zero) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // VENT -> SHUTDOWN stays on the same visible level but still counts as escalation
    assign w_escalate = (level_of(w_next) > level_of(r_state))
                      || (r_state == ST_VENT && w_next == ST_SHUTDOWN)
                      || w_rearm;

    // State register with registered actuators, beep counter and irq
    always_ff @(posedge clk) begin
        if (arst) begin
            r_state    <= ST_IDLE;
            r_warn_cnt <= '0;
            r_beep_cnt <= '0;
            r_level    <= LVL_IDLE;
            r_fan      <= 1'b0;
            r_buzzer   <= 1'b0;
            r_valve    <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_warn_cnt <= w_warn_next;
            r_level    <= level_of(w_next);
            r_fan      <= (w_next == ST_ALARM) || (w_next == ST_SHUTDOWN) || (w_next == ST_VENT);
            r_valve    <= (w_next == ST_SHUTDOWN) || (w_next == ST_VENT);
            if (w_next == ST_ALARM) begin
                if (r_state != ST_ALARM) begin
                    r_buzzer   <= 1'b1;
                    r_beep_cnt <= '0;
                end else if (r_beep_cnt == BEEP_LAST) begin
                    r_buzzer   <= ~r_buzzer;
                    r_beep_cnt <= '0;
                end else begin
                    r_beep_cnt <= r_beep_cnt + 1'b1;
                end
            end else begin
                r_buzzer   <= (w_next == ST_SHUTDOWN);
                r_beep_cnt <= '0;
            end
            if (w_escalate)        r_irq <= 1'b1;
            else if (bus.user_ack) r_irq <= 1'b0;
        end
    end

    assign bus.alarm_level = r_level;
    assign bus.fan_on      = r_fan;
    assign bus.buzzer      = r_buzzer;
    assign bus.valve_close = r_valve;
    assign bus.irq         = r_irq;

`ifdef GAS_CTRL_LOG_EN
    logic [7:0] r_shutdown_cnt;
    logic [2:0] r_last_code;

    // Event log: saturating SHUTDOWN entry count and latest nonzero event code
    always_ff @(posedge clk) begin
        if (arst) begin
            r_shutdown_cnt <= '0;
            r_last_code    <= '0;
        end else begin
            if (w_next == ST_SHUTDOWN && r_state != ST_SHUTDOWN && r_shutdown_cnt != 8'hFF)
                r_shutdown_cnt <= r_shutdown_cnt + 1'b1;
            if (w_any)
                r_last_code <= bus.det_code;
        end
    end

    assign bus.shutdown_cnt = r_shutdown_cnt;
    assign bus.last_code    = r_last_code;
`endif
endmodule

// File: tb/tb_gas_alarm_controller.sv
// Directed self-checking bench for gas_alarm_controller with default parameters.
// Inputs change 1 ns after a rising edge; outputs are read at that same point.
module tb_gas_alarm_controller;
    logic clk;
    logic arst;
    int   n_checks;
    int   n_errors;

    gas_alarm_controller_if u_if ();

    gas_alarm_controller u_dut (
        .clk  (clk),
        .arst (arst),
        .bus  (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock edge; afterwards outputs reflect inputs sampled at it
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic [2:0] code);
        u_if.det_code = code;
        tick();
        u_if.det_code = 3'b000;
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tick(2);
        arst = 1'b0;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] lvl, input logic fan,
                              input logic buz, input logic valve, input logic irq);
        check({tag, "_level"}, 8'(u_if.alarm_level), 8'(lvl));
        check({tag, "_fan"},   8'(u_if.fan_on),      8'(fan));
        check({tag, "_buz"},   8'(u_if.buzzer),      8'(buz));
        check({tag, "_valve"}, 8'(u_if.valve_close), 8'(valve));
        check({tag, "_irq"},   8'(u_if.irq),         8'(irq));
    endtask

    // Hard stop in case the stimulus itself ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        u_if.det_code   = 3'b000;
        u_if.user_ack   = 1'b0;
        u_if.user_reset = 1'b0;
        arst            = 1'b0;
        do_reset();
        check_outs("rst", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Single low-concentration pulse: WARN, then IDLE 16 edges later
        pulse(3'b001);
        check_outs("warn", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(15);
        check("warn_hold_level", 8'(u_if.alarm_level), 8'd1);
        tick();
        check("warn_expire_level", 8'(u_if.alarm_level), 8'd0);
        check("warn_expire_irq", 8'(u_if.irq), 8'd1);
        u_if.user_ack = 1'b1;
        tick();
        u_if.user_ack = 1'b0;
        check("ack_clears_irq", 8'(u_if.irq), 8'd0);

        // Three low pulses five cycles apart escalate to ALARM
        pulse(3'b001);
        u_if.user_ack = 1'b1;
        tick();
        u_if.user_ack = 1'b0;
        check("esc_irq_acked", 8'(u_if.irq), 8'd0);
        tick(3);
        pulse(3'b001);
        check("esc_second_level", 8'(u_if.alarm_level), 8'd1);
        tick(4);
        pulse(3'b001);
        check_outs("esc_alarm", 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        for (int k = 1; k < 12; k++) begin
            tick();
            check($sformatf("beep_%0d", k), 8'(u_if.buzzer), 8'(((k / 4) % 2) == 0));
        end

        // Reset mid-ALARM clears everything
        do_reset();
        check_outs("rst_alarm", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Critical leak straight from IDLE; ack with a new leak keeps irq
        pulse(3'b111);
        check_outs("shut", 2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
        u_if.user_ack = 1'b1;
        u_if.det_code = 3'b100;
        tick();
        u_if.det_code = 3'b000;
        check("ack_leak_irq", 8'(u_if.irq), 8'd1);
        tick();
        u_if.user_ack = 1'b0;
        check("ack_shut_irq", 8'(u_if.irq), 8'd0);

        // Manual reset ignored with an event, accepted without, then vent
        u_if.user_reset = 1'b1;
        u_if.det_code   = 3'b010;
        tick();
        check_outs("rst_with_evt", 2'd3, 1'b1, 1'b1, 1'b1, 1'b0);
        u_if.det_code = 3'b000;
        tick();
        u_if.user_reset = 1'b0;
        check_outs("vent", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(63);
        check("vent_hold_valve", 8'(u_if.valve_close), 8'd1);
        tick();
        check_outs("vent_done", 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Event during VENT returns to SHUTDOWN as a fresh escalation
        do_reset();
        pulse(3'b100);
        u_if.user_ack = 1'b1;
        tick();
        u_if.user_ack   = 1'b0;
        u_if.user_reset = 1'b1;
        tick();
        u_if.user_reset = 1'b0;
        tick(10);
        check_outs("vent10", 2'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        pulse(3'b001);
        check_outs("vent_reshut", 2'd3, 1'b1, 1'b1, 1'b1, 1'b1);
`ifdef GAS_CTRL_LOG_EN
        check("log_shutdown_cnt", u_if.shutdown_cnt, 8'd2);
        check("log_last_code", 8'(u_if.last_code), 8'd1);
`endif

        // High beats low in IDLE; ALARM decays to WARN then IDLE without touching irq
        do_reset();
        pulse(3'b011);
        check_outs("prio_alarm", 2'd2, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(15);
        check("alarm_hold_level", 8'(u_if.alarm_level), 8'd2);
        tick();
        check_outs("alarm_to_warn", 2'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(15);
        check("rewarn_hold_level", 8'(u_if.alarm_level), 8'd1);
        tick();
        check_outs("rewarn_to_idle", 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
